// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the arbiter state encoding and the registered bus request bundle.
package memory_arbiter_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int BE_WIDTH  = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA_ACCESS,
    INSTR_ACCESS
  } arb_state_t;

  typedef logic [BUS_WIDTH-1:0] word_t;
  typedef logic [BE_WIDTH-1:0]  be_t;

  typedef struct packed {
    word_t addr;
    word_t wdata;
    be_t   be;
    logic  write;
  } bus_req_t;

endpackage

// File: rtl/memory_arbiter_wait_timeout_counter.sv
// Saturating count of consecutive bus wait cycles within one access.
// reached stays high once the limit is hit until the next clear.
module wait_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_enable,
  output logic reached
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX = CW'(LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign reached = (count == MAX);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a fetch port and a data port onto one waitrequest-style bus.
// Alternates between requesters and flags overlong bus stalls.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_req,
  input  logic [BUS_WIDTH-1:0] instr_address,
  output logic [BUS_WIDTH-1:0] instr_readdata,
  output logic                 instr_valid,
  input  logic                 data_read,
  input  logic                 data_write,
  input  logic [BUS_WIDTH-1:0] data_address,
  input  logic [BUS_WIDTH-1:0] data_writedata,
  input  logic [BE_WIDTH-1:0]  data_byteenable,
  output logic [BUS_WIDTH-1:0] data_readdata,
  output logic                 data_valid,
  output logic [BUS_WIDTH-1:0] bus_address,
  output logic                 bus_read,
  output logic                 bus_write,
  output logic [BUS_WIDTH-1:0] bus_writedata,
  output logic [BE_WIDTH-1:0]  bus_byteenable,
  input  logic [BUS_WIDTH-1:0] bus_readdata,
  input  logic                 bus_waitrequest,
  output logic                 stall,
  output logic                 timeout_error
);

  arb_state_t state;
  arb_state_t state_next;
  bus_req_t   bus_q;

  logic in_access;
  logic done;
  logic data_done;
  logic instr_done;
  logic data_req;
  logic data_pend;
  logic instr_pend;
  logic arbitrate;
  logic grant_data;
  logic grant_instr;
  logic reached;
  logic err_q;

  assign in_access  = (state != IDLE);
  assign done       = in_access && !bus_waitrequest;
  assign data_done  = done && (state == DATA_ACCESS);
  assign instr_done = done && (state == INSTR_ACCESS);
  assign data_req   = data_read || data_write;

  // A completing requester still holds its strobe; that is the
  // request just served, not a new one.
  assign data_pend  = data_req && !data_valid && !data_done;
  assign instr_pend = instr_req && !instr_valid && !instr_done;

  assign arbitrate   = (state == IDLE) || done;
  assign grant_data  = arbitrate && data_pend &&
                       !((state == DATA_ACCESS) && instr_pend);
  assign grant_instr = arbitrate && instr_pend && !grant_data;

  always_comb begin
    state_next = state;
    bus_read   = 1'b0;
    bus_write  = 1'b0;
    if (grant_data) begin
      state_next = DATA_ACCESS;
    end else if (grant_instr) begin
      state_next = INSTR_ACCESS;
    end else if (arbitrate) begin
      state_next = IDLE;
    end
    if (in_access) begin
      bus_read  = !bus_q.write;
      bus_write = bus_q.write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q          <= '0;
      instr_readdata <= '0;
      data_readdata  <= '0;
      instr_valid    <= 1'b0;
      data_valid     <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      instr_valid <= instr_done;
      data_valid  <= data_done;
      err_q       <= err_q || reached;
      if (instr_done) begin
        instr_readdata <= bus_readdata;
      end
      if (data_done && !bus_q.write) begin
        data_readdata <= bus_readdata;
      end
      if (grant_data) begin
        bus_q <= '{addr:  data_address,
                   wdata: data_writedata,
                   be:    data_byteenable,
                   write: data_write};
      end else if (grant_instr) begin
        bus_q <= '{addr:  instr_address,
                   wdata: '0,
                   be:    '1,
                   write: 1'b0};
      end
    end
  end

  wait_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk         (clk),
    .reset       (reset),
    .clear       (grant_data || grant_instr),
    .count_enable(in_access && bus_waitrequest),
    .reached     (reached)
  );

  assign bus_address    = bus_q.addr;
  assign bus_writedata  = bus_q.wdata;
  assign bus_byteenable = bus_q.be;

  assign timeout_error = err_q || reached;

  assign stall = (instr_req && !instr_valid) ||
                 (data_req && !data_valid);

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: requester models, a waitrequest
// bus slave, and per-scenario cycle checks.
module tb_memory_arbiter;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_address = '0;
  logic [31:0] instr_readdata;
  logic        instr_valid;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] data_writedata = '0;
  logic [3:0]  data_byteenable = '0;
  logic [31:0] data_readdata;
  logic        data_valid;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_readdata;
  logic        bus_waitrequest;
  logic        stall;
  logic        timeout_error;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dcmd_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_be;
  } bexp_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
  } dexp_t;

  dcmd_t       dcmd_q[$];
  logic [31:0] icmd_q[$];
  bexp_t       exp_bus[$];
  logic [31:0] exp_instr[$];
  dexp_t       exp_data[$];

  logic [31:0] last_drd = '0;
  int          checks = 0;
  int          errors = 0;
  bit          flush = 1'b0;
  int          wait_cfg = 0;
  int          wait_left = 0;

  memory_arbiter #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_req      (instr_req),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .instr_valid    (instr_valid),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_address   (data_address),
    .data_writedata (data_writedata),
    .data_byteenable(data_byteenable),
    .data_readdata  (data_readdata),
    .data_valid     (data_valid),
    .bus_address    (bus_address),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_writedata  (bus_writedata),
    .bus_byteenable (bus_byteenable),
    .bus_readdata   (bus_readdata),
    .bus_waitrequest(bus_waitrequest),
    .stall          (stall),
    .timeout_error  (timeout_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2402_0005
                                : ((a ^ 32'h5A5A_A5A5) + 32'd1);
  endfunction

  assign bus_readdata    = mem_rd(bus_address);
  assign bus_waitrequest = (bus_read || bus_write) && (wait_left != 0);

  // Slave: wait_cfg wait cycles at the start of every access.
  always @(posedge clk) begin
    if (reset || !(bus_read || bus_write) || !bus_waitrequest)
      wait_left <= wait_cfg;
    else
      wait_left <= wait_left - 1;
  end

  always @(posedge clk) begin : instr_requester
    #1;
    if (flush) begin
      instr_req = 1'b0;
      icmd_q.delete();
    end else begin
      if (instr_req && instr_valid) instr_req = 1'b0;
      if (!instr_req && icmd_q.size() != 0) begin
        instr_address = icmd_q.pop_front();
        instr_req = 1'b1;
      end
    end
  end

  always @(posedge clk) begin : data_requester
    dcmd_t c;
    #1;
    if (flush) begin
      data_read  = 1'b0;
      data_write = 1'b0;
      dcmd_q.delete();
    end else begin
      if ((data_read || data_write) && data_valid) begin
        data_read  = 1'b0;
        data_write = 1'b0;
      end
      if (!(data_read || data_write) && dcmd_q.size() != 0) begin
        c = dcmd_q.pop_front();
        data_read       = c.rd;
        data_write      = c.wr;
        data_address    = c.addr;
        data_writedata  = c.wdata;
        data_byteenable = c.be;
      end
    end
  end

  always @(negedge clk) begin : monitor
    bexp_t       e;
    dexp_t       d;
    logic [31:0] ir;
    if (!reset) begin
      if ((bus_read || bus_write) && !bus_waitrequest) begin
        checks++;
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected got r%b w%b a=%h want none",
                   bus_read, bus_write, bus_address);
        end else begin
          e = exp_bus.pop_front();
          if (bus_write !== e.wr || bus_read !== !e.wr ||
              bus_address !== e.addr ||
              (e.wr && bus_writedata !== e.wdata) ||
              (e.chk_be && bus_byteenable !== e.be)) begin
            errors++;
            $display("FAIL bus_access got w%b a=%h d=%h be=%h want w%b a=%h d=%h be=%h",
                     bus_write, bus_address, bus_writedata, bus_byteenable,
                     e.wr, e.addr, e.wdata, e.be);
          end
        end
      end
      if (instr_valid) begin
        checks++;
        if (exp_instr.size() == 0) begin
          errors++;
          $display("FAIL instr_valid_unexpected got %h want none",
                   instr_readdata);
        end else begin
          ir = exp_instr.pop_front();
          if (instr_readdata !== ir) begin
            errors++;
            $display("FAIL instr_readdata got %h want %h",
                     instr_readdata, ir);
          end
        end
      end
      if (data_valid) begin
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL data_valid_unexpected got %h want none",
                   data_readdata);
        end else begin
          d = exp_data.pop_front();
          if (!d.wr) last_drd = d.rdata;
          if (data_readdata !== last_drd) begin
            errors++;
            $display("FAIL data_readdata got %h want %h",
                     data_readdata, last_drd);
          end
        end
      end
    end
  end

  task automatic issue_instr(input logic [31:0] a);
    icmd_q.push_back(a);
    exp_instr.push_back(mem_rd(a));
  endtask

  task automatic issue_data(input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
    dexp_t d;
    dcmd_q.push_back('{rd: rd, wr: wr, addr: a, wdata: wd, be: be});
    d.wr = wr;
    d.rdata = wr ? 32'h0 : mem_rd(a);
    exp_data.push_back(d);
  endtask

  task automatic expect_bus(input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic chk_be);
    exp_bus.push_back('{wr: wr, addr: a, wdata: wd, be: be, chk_be: chk_be});
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (exp_bus.size() == 0 && exp_instr.size() == 0 &&
          exp_data.size() == 0 && icmd_q.size() == 0 &&
          dcmd_q.size() == 0 && !instr_req && !data_read &&
          !data_write && !bus_read && !bus_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus_read, bus_write, instr_valid, data_valid,
         timeout_error, stall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {bus_read, bus_write, instr_valid, data_valid,
                timeout_error, stall});
    end
    checks++;
    if ({bus_address, bus_writedata, bus_byteenable} !== 68'h0) begin
      errors++;
      $display("FAIL reset_bus got a=%h d=%h be=%h want 0",
               bus_address, bus_writedata, bus_byteenable);
    end
    checks++;
    if ({instr_readdata, data_readdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h %h want 0",
               instr_readdata, data_readdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b0 || bus_write !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got r%b w%b want 0 0",
               bus_read, bus_write);
    end
  endtask

  task automatic test_fetch_latency();
    bit ok;
    @(negedge clk);
    wait_cfg = 0;
    issue_instr(32'hBFC0_0000);
    expect_bus(1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL fetch_cycle_n got r%b stall%b want r0 stall1",
               bus_read, stall);
    end
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b1 || bus_address !== 32'hBFC0_0000) begin
      errors++;
      $display("FAIL fetch_strobe got r%b a=%h want r1 a=bfc00000",
               bus_read, bus_address);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_readdata !== 32'h2402_0005) begin
      errors++;
      $display("FAIL fetch_valid got v%b d=%h want v1 d=24020005",
               instr_valid, instr_readdata);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || bus_read !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pulse got v%b r%b want v0 r0",
               instr_valid, bus_read);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fetch_drain got pending want drained");
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    @(negedge clk);
    wait_cfg = 0;
    issue_data(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    issue_instr(32'h2000_0040);
    expect_bus(1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b1);
    expect_bus(1'b0, 32'h2000_0040, 32'h0, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || bus_read !== 1'b0) begin
      errors++;
      $display("FAIL simul_n got stall%b r%b want stall1 r0",
               stall, bus_read);
    end
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b1 || bus_address !== 32'h0000_1000 ||
        stall !== 1'b1) begin
      errors++;
      $display("FAIL simul_data_first got r%b a=%h stall%b want r1 a=00001000 stall1",
               bus_read, bus_address, stall);
    end
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b1 || bus_address !== 32'h2000_0040 ||
        data_valid !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL simul_instr_next got r%b a=%h dv%b stall%b want r1 a=20000040 dv1 stall1",
               bus_read, bus_address, data_valid, stall);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || stall !== 1'b0 || bus_read !== 1'b0) begin
      errors++;
      $display("FAIL simul_done got iv%b stall%b r%b want iv1 stall0 r0",
               instr_valid, stall, bus_read);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL simul_drain got pending want drained");
    end
  endtask

  task automatic test_write_wait();
    bit ok;
    bit vseen = 1'b0;
    bit stall_bad = 1'b0;
    bit unstable = 1'b0;
    int wr_cycles = 0;
    int vcount = 0;
    @(negedge clk);
    wait_cfg = 3;
    issue_data(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    expect_bus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    @(posedge clk);
    #2;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (data_valid) begin
        vcount++;
        vseen = 1'b1;
      end
      if (!vseen && stall !== 1'b1) stall_bad = 1'b1;
      if (bus_write) begin
        wr_cycles++;
        if (bus_address !== 32'h10 || bus_writedata !== 32'hDEAD_BEEF ||
            bus_byteenable !== 4'hF || bus_read !== 1'b0)
          unstable = 1'b1;
      end
    end
    checks++;
    if (wr_cycles != 4) begin
      errors++;
      $display("FAIL write_hold got %0d cycles want 4", wr_cycles);
    end
    checks++;
    if (vcount != 1) begin
      errors++;
      $display("FAIL write_valid_count got %0d want 1", vcount);
    end
    checks++;
    if (stall_bad || unstable) begin
      errors++;
      $display("FAIL write_stall_stable got stall_bad=%b unstable=%b want 0 0",
               stall_bad, unstable);
    end
    checks++;
    if (timeout_error !== 1'b0) begin
      errors++;
      $display("FAIL write_no_timeout got %b want 0", timeout_error);
    end
    wait_cfg = 0;
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_drain got pending want drained");
    end
  endtask

  task automatic test_data_patterns();
    bit ok;
    @(negedge clk);
    wait_cfg = 1;
    issue_data(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    issue_data(1'b0, 1'b1, 32'h104, 32'h1122_3344, 4'h3);
    issue_data(1'b1, 1'b1, 32'h108, 32'hCAFE_F00D, 4'hC);
    issue_data(1'b1, 1'b0, 32'h10C, 32'h0, 4'h1);
    expect_bus(1'b0, 32'h100, 32'h0, 4'hF, 1'b1);
    expect_bus(1'b1, 32'h104, 32'h1122_3344, 4'h3, 1'b1);
    expect_bus(1'b1, 32'h108, 32'hCAFE_F00D, 4'hC, 1'b1);
    expect_bus(1'b0, 32'h10C, 32'h0, 4'h1, 1'b1);
    wait_drain(80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL patterns_drain got pending want drained");
    end
    wait_cfg = 0;
  endtask

  task automatic test_alternation();
    bit ok;
    @(negedge clk);
    wait_cfg = 0;
    issue_data(1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF);
    issue_data(1'b1, 1'b0, 32'h3000_0004, 32'h0, 4'hF);
    issue_data(1'b1, 1'b0, 32'h3000_0008, 32'h0, 4'hF);
    issue_instr(32'h2000_0100);
    issue_instr(32'h2000_0104);
    expect_bus(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b1);
    expect_bus(1'b0, 32'h2000_0100, 32'h0, 4'hF, 1'b0);
    expect_bus(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b1);
    expect_bus(1'b0, 32'h2000_0104, 32'h0, 4'hF, 1'b0);
    expect_bus(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1'b1);
    wait_drain(60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL alternation_drain got pending want drained");
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit got = 1'b0;
    @(negedge clk);
    wait_cfg = 6;
    issue_instr(32'h2000_0200);
    expect_bus(1'b0, 32'h2000_0200, 32'h0, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    repeat (5) @(negedge clk);
    checks++;
    if (timeout_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %b want 0 after 3 waits",
               timeout_error);
    end
    @(negedge clk);
    checks++;
    if (timeout_error !== 1'b1 || bus_read !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set got err%b r%b want err1 r1",
               timeout_error, bus_read);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout_complete got no valid want valid");
    end
    wait_cfg = 0;
    @(negedge clk);
    issue_instr(32'h2000_0204);
    expect_bus(1'b0, 32'h2000_0204, 32'h0, 4'hF, 1'b0);
    wait_drain(30, ok);
    checks++;
    if (!ok || timeout_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got drained%b err%b want 1 1",
               ok, timeout_error);
    end
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    bit bad = 1'b0;
    @(negedge clk);
    wait_cfg = 20;
    issue_instr(32'h2000_0300);
    expect_bus(1'b0, 32'h2000_0300, 32'h0, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_read !== 1'b1) begin
      errors++;
      $display("FAIL rst_precondition got r%b want r1", bus_read);
    end
    #2;
    reset = 1'b1;
    flush = 1'b1;
    exp_bus.delete();
    exp_instr.delete();
    last_drd = '0;
    #1;
    checks++;
    if (bus_read !== 1'b0 || timeout_error !== 1'b0 ||
        bus_address !== 32'h0 || instr_readdata !== 32'h0 ||
        data_readdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_async got r%b err%b a=%h ir=%h dr=%h want 0",
               bus_read, timeout_error, bus_address,
               instr_readdata, data_readdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (instr_valid || data_valid || bus_read || bus_write) bad = 1'b1;
    end
    reset = 1'b0;
    flush = 1'b0;
    wait_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (instr_valid || data_valid || bus_read || bus_write) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_no_valid got activity want none");
    end
    issue_instr(32'h2000_0304);
    expect_bus(1'b0, 32'h2000_0304, 32'h0, 4'hF, 1'b0);
    wait_drain(30, ok);
    checks++;
    if (!ok || timeout_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover got drained%b err%b want 1 0",
               ok, timeout_error);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_latency();
    test_simultaneous();
    test_write_wait();
    test_data_patterns();
    test_alternation();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
